// File: rtl/ram_sp_clr_pkg.sv
// Shared FSM encodings and lane-count helper for the clearable single-port RAM.
package ram_sp_clr_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  function automatic int lanes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear engine: walks every word address once after reset or a clr pulse, holding busy meanwhile.
// Counter is one bit wider than the address so the terminal compare is unambiguous.
module ram_clear_ctrl
  import ram_sp_clr_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  output logic          busy_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);

  localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};

  logic [0:0] state_q, state_d;
  logic [AW:0] cnt_q, cnt_d;
  logic busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    end else if (clr_i) begin
      state_d = ST_CLEAR;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign clr_we_o   = (state_q == ST_CLEAR);
  assign clr_addr_o = cnt_q[AW-1:0];

endmodule

// File: rtl/ram_sp_clr.sv
// Single-port RAM with byte enables, read-valid strobe and hardware clear; read latency 1,
// or 2 when RAM_OUTREG_EN is defined. Accesses while busy or coinciding with clr are dropped.
module ram_sp_clr
  import ram_sp_clr_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              we,
  input  logic [DW/8-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     wdata,
  input  logic              clr,
  output logic [DW-1:0]     rdata,
  output logic              rvalid,
  output logic              busy
);

  localparam int NB    = lanes(DW);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          acc, wr_acc, rd_acc;
  logic [DW-1:0] rdata_q;
  logic          rvalid_q;

  ram_clear_ctrl #(.AW(AW)) u_clear_ctrl (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign acc    = ce && !busy && !clr;
  assign wr_acc = acc && we;
  assign rd_acc = acc && !we;

  // The clear pass owns the write port; user writes cannot overlap it because busy gates them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem_q[clr_addr] <= '0;
      end else if (wr_acc) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) rdata_q <= mem_q[addr];
    end
  end

`ifdef RAM_OUTREG_EN
  logic [DW-1:0] rdata2_q;
  logic          rvalid2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata2_q  <= '0;
      rvalid2_q <= 1'b0;
    end else begin
      rvalid2_q <= rvalid_q;
      if (rvalid_q) rdata2_q <= rdata_q;
    end
  end

  assign rdata  = rdata2_q;
  assign rvalid = rvalid2_q;
`else
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
`endif

endmodule

// File: tb/tb_ram_sp_clr.sv
// Directed bench for ram_sp_clr (AW=8, DW=16); read latency follows RAM_OUTREG_EN.
module tb_ram_sp_clr;

`ifdef RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, ce, we, clr;
  logic [1:0]  be;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rvalid, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_sp_clr #(.AW(8), .DW(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .we     (we),
    .be     (be),
    .addr   (addr),
    .wdata  (wdata),
    .clr    (clr),
    .rdata  (rdata),
    .rvalid (rvalid),
    .busy   (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
    ce = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
    tick();
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [15:0] exp);
    ce = 1'b1; we = 1'b0; addr = a;
    tick();
    ce = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      chk({tag, "_early"}, 32'(rvalid), 32'd0);
      tick();
    end
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, "_rdata"}, 32'(rdata), 32'(exp));
    tick();
    chk({tag, "_rvalid_drop"}, 32'(rvalid), 32'd0);
  endtask

  // Counts edges until busy falls; bounded so a stuck busy still reaches the summary.
  task automatic wait_idle(input string tag, input int exp_edges, input int repulse_at);
    int n = 0;
    while (busy && n < 1000) begin
      clr = (n == repulse_at);
      tick();
      n++;
    end
    clr = 1'b0;
    chk(tag, 32'(n), 32'(exp_edges));
  endtask

  logic [15:0] exp3 [3];

  initial begin
    rst = 1'b1; ce = 1'b0; we = 1'b0; clr = 1'b0; be = 2'b00; addr = '0; wdata = '0;
    exp3[0] = 16'h5555; exp3[1] = 16'hBBBB; exp3[2] = 16'hCCCC;

    // Test 1: reset state, initial clear duration, cleared contents
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    rst = 1'b0;
    wait_idle("init_clear_edges", 256, -1);
    read_chk("t1_rd00", 8'h00, 16'h0000);
    read_chk("t1_rdff", 8'hFF, 16'h0000);

    // Test 2: full writes then back-to-back reads
    do_write(8'h00, 16'h5555, 2'b11);
    do_write(8'h01, 16'hBBBB, 2'b11);
    do_write(8'h02, 16'hCCCC, 2'b11);
    for (int k = 0; k < 5; k++) begin
      ce = (k < 3); we = 1'b0; addr = 8'(k);
      tick();
      if (k >= LAT - 1 && k <= LAT + 1) begin
        chk($sformatf("t2_rvalid%0d", k), 32'(rvalid), 32'd1);
        chk($sformatf("t2_rdata%0d", k), 32'(rdata), 32'(exp3[k-(LAT-1)]));
      end else begin
        chk($sformatf("t2_rvalid%0d", k), 32'(rvalid), 32'd0);
      end
    end
    ce = 1'b0;

    // Test 3: byte-lane merging; be=00 is a no-op; read right after write
    do_write(8'h10, 16'hABCD, 2'b11);
    do_write(8'h10, 16'h1234, 2'b01);
    do_write(8'h10, 16'h9999, 2'b00);
    read_chk("t3_lanes", 8'h10, 16'hAB34);

    // Test 4: accesses during busy are ignored; clr while clearing does not restart
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t4_busy_after_clr", 32'(busy), 32'd1);
    ce = 1'b1; we = 1'b1; addr = 8'h05; wdata = 16'hFFFF; be = 2'b11;
    tick();
    we = 1'b0; addr = 8'h06;
    tick();
    ce = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      chk($sformatf("t4_no_rvalid%0d", i), 32'(rvalid), 32'd0);
      tick();
    end
    chk("t4_rdata_held", 32'(rdata), 32'h0000AB34);
    wait_idle("t4_clear_edges", 256 - LAT - 2, 50);
    read_chk("t4_rd05", 8'h05, 16'h0000);

    // Test 5: clr wins over a coincident write; rst mid-clear restarts the pass
    do_write(8'h07, 16'h2222, 2'b11);
    read_chk("t5_pre", 8'h07, 16'h2222);
    clr = 1'b1; ce = 1'b1; we = 1'b1; addr = 8'h07; wdata = 16'h1111; be = 2'b11;
    tick();
    clr = 1'b0; ce = 1'b0; we = 1'b0;
    wait_idle("t5_clear_edges", 256, -1);
    read_chk("t5_rd07", 8'h07, 16'h0000);
    read_chk("t5_rd00", 8'h00, 16'h0000);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    repeat (2) tick();
    chk("t5_busy_in_rst", 32'(busy), 32'd1);
    chk("t5_rdata_rst", 32'(rdata), 32'd0);
    rst = 1'b0;
    wait_idle("t5_restart_edges", 256, -1);
    read_chk("t5_rd01", 8'h01, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
